// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, 8 data bits LSB first, optional even parity, 1 stop bit.
// Define UART_RX_PARITY_EN to include the parity bit; otherwise parity_err is tied low.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on an armed (previously high) line
  // START  | counting to mid start bit to reject glitches
  // DATA   | sampling 8 data bits at bit centre
  // PARITY | sampling the even-parity bit
  // STOP   | sampling the stop bit, then publishing the frame
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [3:0] S_STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

  logic [2:0] state;
  logic [3:0] s_reg;
  logic [2:0] n_reg;
  logic [7:0] b_reg;
  logic       armed;
  logic       rx_meta;
  logic       rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic p_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      p_bit <= 1'b0;
    else if (state == PARITY && s_tick && s_reg == 4'd15)
      p_bit <= rx_s;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_reg        <= 4'd0;
      n_reg        <= 3'd0;
      b_reg        <= 8'h00;
      armed        <= 1'b0;
      dout         <= 8'h00;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // armed keeps a held-low line (break) from retriggering a frame
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            s_reg <= 4'd0;
            armed <= 1'b0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == 4'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s_reg <= 4'd0;
                n_reg <= 3'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_reg <= s_reg + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == 4'd15) begin
              b_reg <= {rx_s, b_reg[7:1]};
              s_reg <= 4'd0;
              if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n_reg <= n_reg + 3'd1;
              end
            end else begin
              s_reg <= s_reg + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_reg == 4'd15) begin
              state <= STOP;
              s_reg <= 4'd0;
            end else begin
              s_reg <= s_reg + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s_reg == S_STOP_LAST) begin
              state        <= IDLE;
              dout         <= b_reg;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err   <= p_bit ^ (^b_reg);
`else
              parity_err   <= 1'b0;
`endif
            end else begin
              s_reg <= s_reg + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with `tx`. It samples the serial line at 16× oversampling using the shared baud-rate `s_tick` and deserialises each frame. A frame is: start, 8 data bits LSB first, optional even-parity bit, 1 stop bit. For each frame it presents the received byte with parity and framing status to the downstream consumer (FIFO or host logic).

## Interface
- `DBIT`, default 8: data bits per frame (fixed at 8 for this design).
- `SB_TICK`, default 16: `s_tick`s spent in the stop bit (16 = 1 stop bit).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line; asynchronous to `clk`; idles high.
- `s_tick`  in  1  one-`clk` pulse at 16× baud, from the baud generator.
- `dout`  out  8  last received byte; held until the next completed frame.
- `rx_done_tick`  out  1  one-cycle pulse when `dout`/flags update.
- `parity_err`  out  1  parity status of last frame; held like `dout`.
- `frame_err`  out  1  stop-bit-low status of last frame; held like `dout`.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s`.
- Counters:
  - `s_reg`: 4 bits, 0–15; counts `s_tick`s.
  - `n_reg`: 3 bits, 0–7; counts data bits.
  - `b_reg`: 8-bit shift register.
  - `armed`: 1 bit.
- States: IDLE, START, DATA, PARITY, STOP (3-bit encoding; undefined codes go to IDLE).
- IDLE:
  - `armed` is set while `rx_s` = 1.
  - If `armed` and `rx_s` = 0: go to START, `s_reg` = 0, `armed` cleared.
- START:
  - On `s_tick` with `s_reg` = 7 (mid start bit):
    - `rx_s` = 0: go to DATA, `s_reg` = 0, `n_reg` = 0.
    - Otherwise: glitch; return to IDLE. No done pulse, outputs unchanged.
  - Otherwise, increment on each `s_tick`.
- DATA:
  - On `s_tick` with `s_reg` = 15: `b_reg` = {`rx_s`, `b_reg`[7:1]}, `s_reg` = 0.
  - At `n_reg` = 7: go to PARITY (or STOP if parity is compiled out). Otherwise `n_reg`++.
- PARITY:
  - On `s_tick` with `s_reg` = 15: capture `p_bit` = `rx_s`, go to STOP, `s_reg` = 0.
- STOP:
  - On `s_tick` with `s_reg` = `SB_TICK`−1, update registered outputs and go to IDLE:
    - `dout` = `b_reg`
    - `parity_err` = `p_bit` XOR (^`b_reg`) (even parity: XOR of 8 data + parity must be 0)
    - `frame_err` = ~`rx_s`
    - `rx_done_tick` = 1
- Break (line held low): the frame completes with `frame_err` = 1. No new start is taken until `rx_s` has been seen high (`armed`).
- `s_tick` absent: the FSM holds state indefinitely; there is no timeout.

## Timing
- Reset values: `dout` = 0x00, `rx_done_tick` = 0, `parity_err` = 0, `frame_err` = 0, state IDLE, counters 0, `armed` = 0, synchronizer flops = 1.
- Reset asserted mid-frame: immediate return to IDLE. No done pulse; the partial byte is discarded.
- Input latency: 2 `clk` from `rx` to `rx_s`.
- Frame duration, from the `clk` edge entering START to the `rx_done_tick` edge:
  - With parity: 8 + 16·8 + 16 + `SB_TICK` `s_tick`s = 168 at defaults.
  - Without parity: 152 at defaults.
- `rx_done_tick` is high exactly one `clk` cycle: the cycle after the edge that consumes the final stop `s_tick`. `dout` and flags are valid in that same cycle and stay stable until the next pulse.
- Sampling point is bit centre: tick 8 of each bit relative to the detected falling edge.
- `s_tick` is only counted in the cycle it is high. Consecutive-cycle ticks are each counted.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state present; frame is 11 bits.
  - `parity_err` computed as above.
  - Must match the `tx` parity setting.
- Not defined:
  - PARITY state removed; DATA goes directly to STOP; frame is 10 bits.
  - `parity_err` is tied to 0.

## Test plan
- Good frame, parity on: 16× ticks; send 0xA5 with parity 0 and stop 1 → `dout` = 0xA5, `parity_err` = 0, `frame_err` = 0, single `rx_done_tick` 168 ticks after the falling edge.
- Bad parity: send 0x3C with parity 1 → `dout` = 0x3C, `parity_err` = 1, `frame_err` = 0.
- Framing error: send 0x55 with stop = 0, then hold `rx` low for 3 bit-times → `frame_err` = 1; no second frame until `rx` returns high and falls again.
- Glitch rejection: pulse `rx` low for 4 `s_tick`s → no `rx_done_tick`; `dout` keeps its previous value; FSM back in IDLE.
- Reset mid-frame: assert `reset_n` = 0 during data bit 3 of 0xFF → all outputs 0 immediately; after release, a following 0x12 frame is received correctly.
- Loopback: `tx` → `uart_rx` with a shared tick, bytes 0x00, 0xFF, 0x80, 0x01 back-to-back → each byte matches with no errors; `UART_RX_PARITY_EN` set on both.
